decoder_scan: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder. It has two modes: direct decode of a latched select code, and an autonomous scan mode that walks the outputs with a programmable dwell and a runtime wrap limit. It replaces the fixed combinational 2-to-4 decoder wherever a select must be registered or time-multiplexed, for example digit/row strobing of multiplexed displays. It sits between control logic and output drivers.

---
 rtl/decoder_scan_pkg.sv | 16 +
 rtl/decoder_scan_dwell_counter.sv | 33 +++
 rtl/decoder_scan.sv | 108 ++++++++++
 tb/tb_decoder_scan.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the registered decoder with scan mode:
// FSM state encodings and the dwell-counter width helper.
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Counter width for a dwell of DWELL cycles, never narrower than one bit.
    function automatic int dwell_cnt_w(input int dwell);
        return (dwell <= 2) ? 1 : $clog2(dwell);
    endfunction

endpackage

// File: rtl/decoder_scan_dwell_counter.sv
// Free-running modulo-DWELL counter; tick marks the terminal count and is
// suppressed while clr is asserted so a restart never advances the scan.
module dwell_counter
    import decoder_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = dwell_cnt_w(DWELL);
    localparam logic [CW-1:0] TERM = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;
    logic          w_term;

    assign w_term = (r_cnt == TERM);
    assign tick   = w_term && !clr;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_cnt <= '0;
        end else if (w_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with a direct mode and
// an autonomous scan mode that walks idx 0..last with a fixed dwell.
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic                in_valid,
    input  logic [N-1:0]        i,
    input  logic [N-1:0]        last,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                step,
    output logic                busy
);

    localparam int NOUT = 1 << N;
    localparam logic [NOUT-1:0] Y_OFF = (ACTIVE_LOW != 0) ? {NOUT{1'b1}} : {NOUT{1'b0}};

    function automatic logic [NOUT-1:0] f_decode(input logic [N-1:0] sel);
        logic [NOUT-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~v : v;
    endfunction

    state_t          r_state;
    logic [NOUT-1:0] r_y;
    logic [N-1:0]    r_idx;
    logic            r_step;
    logic            r_busy;

    state_t          w_nxt;
    logic            w_clr;
    logic            w_tick;
    logic [N-1:0]    w_idx_adv;

    always_comb begin
        w_nxt = ST_IDLE;
        if (en) begin
            w_nxt = mode ? ST_SCAN : ST_DIRECT;
        end
    end

    // The dwell count only runs while the scan continues; any entry restarts it.
    assign w_clr     = !((r_state == ST_SCAN) && (w_nxt == ST_SCAN));
    assign w_idx_adv = (r_idx >= last) ? '0 : r_idx + 1'b1;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_y     <= Y_OFF;
            r_idx   <= '0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_busy  <= (w_nxt != ST_IDLE);
            r_step  <= 1'b0;
            case (w_nxt)
                ST_DIRECT: begin
                    if (in_valid) begin
                        r_idx <= i;
                        r_y   <= f_decode(i);
                    end else if (r_state != ST_DIRECT) begin
                        r_idx <= '0;
                        r_y   <= Y_OFF;
                    end
                end
                ST_SCAN: begin
                    if (r_state != ST_SCAN) begin
                        r_idx <= '0;
                        r_y   <= f_decode('0);
                    end else if (w_tick) begin
                        r_step <= 1'b1;
                        r_idx  <= w_idx_adv;
                        r_y    <= f_decode(w_idx_adv);
                    end
                end
                default: begin
                    r_idx <= '0;
                    r_y   <= Y_OFF;
                end
            endcase
        end
    end

    assign y    = r_y;
    assign idx  = r_idx;
    assign step = r_step;
    assign busy = r_busy;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: instance A (N=2, DWELL=3, active-high)
// and instance B (N=3, DWELL=2, active-low).
module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_na, en_a, mode_a, iv_a;
    logic [1:0] i_a, last_a;
    logic [3:0] y_a;
    logic [1:0] idx_a;
    logic       step_a, busy_a;

    logic       rst_nb, en_b, mode_b, iv_b;
    logic [2:0] i_b, last_b;
    logic [7:0] y_b;
    logic [2:0] idx_b;
    logic       step_b, busy_b;

    decoder_scan #(.N(2), .DWELL(3), .ACTIVE_LOW(0)) u_dut_a (
        .clk(clk), .rst_n(rst_na), .en(en_a), .mode(mode_a), .in_valid(iv_a),
        .i(i_a), .last(last_a), .y(y_a), .idx(idx_a), .step(step_a), .busy(busy_a)
    );

    decoder_scan #(.N(3), .DWELL(2), .ACTIVE_LOW(1)) u_dut_b (
        .clk(clk), .rst_n(rst_nb), .en(en_b), .mode(mode_b), .in_valid(iv_b),
        .i(i_b), .last(last_b), .y(y_b), .idx(idx_b), .step(step_b), .busy(busy_b)
    );

    typedef struct {
        bit         chk;
        bit         dut;
        logic [7:0] y;
        logic [2:0] idx;
        bit         stp;
        bit         bsy;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // One expectation per clock edge; inputs are already set by the caller.
    task automatic cyc(input bit chk, input bit dut, input logic [7:0] y,
                       input logic [2:0] idx, input bit stp, input bit bsy,
                       input string name);
        exp_t e;
        e.chk = chk; e.dut = dut; e.y = y; e.idx = idx;
        e.stp = stp; e.bsy = bsy; e.name = name;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [7:0] gy;
        logic [2:0] gi;
        logic       gs, gb;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    gy = e.dut ? y_b : {4'b0, y_a};
                    gi = e.dut ? idx_b : {1'b0, idx_a};
                    gs = e.dut ? step_b : step_a;
                    gb = e.dut ? busy_b : busy_a;
                    n_vec++;
                    if (gy !== e.y || gi !== e.idx || gs !== e.stp || gb !== e.bsy) begin
                        n_err++;
                        $display("FAIL %s: got y=%h idx=%0d step=%b busy=%b, want y=%h idx=%0d step=%b busy=%b",
                                 e.name, gy, gi, gs, gb, e.y, e.idx, e.stp, e.bsy);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int id;
        rst_na = 1'b0; en_a = 1'b0; mode_a = 1'b0; iv_a = 1'b0; i_a = '0; last_a = 2'd3;
        rst_nb = 1'b0; en_b = 1'b0; mode_b = 1'b0; iv_b = 1'b0; i_b = '0; last_b = 3'd7;

        cyc(1, 0, 8'h00, 3'd0, 0, 0, "rst_a0");
        cyc(1, 0, 8'h00, 3'd0, 0, 0, "rst_a1");
        cyc(1, 1, 8'hFF, 3'd0, 0, 0, "rst_b");

        rst_na = 1'b1; en_a = 1'b1; mode_a = 1'b0; iv_a = 1'b1;
        for (int d = 0; d < 4; d++) begin
            i_a = 2'(d);
            cyc(1, 0, 8'd1 << d, 3'(d), 0, 1, "direct");
        end
        iv_a = 1'b0; i_a = 2'd1;
        cyc(1, 0, 8'h08, 3'd3, 0, 1, "hold0");
        cyc(1, 0, 8'h08, 3'd3, 0, 1, "hold1");

        mode_a = 1'b1; last_a = 2'd3;
        for (int k = 0; k < 12; k++) begin
            id = (k / 3) % 4;
            cyc(1, 0, 8'd1 << id, 3'(id), (k > 0) && (k % 3 == 0), 1, "scan3");
        end

        // idx is 3 with one cycle of dwell left: shrinking last forces a wrap.
        last_a = 2'd1;
        for (int k = 12; k < 24; k++) begin
            id = ((k - 12) / 3) % 2;
            cyc(1, 0, 8'd1 << id, 3'(id), (k % 3 == 0), 1, "wrap1");
        end

        last_a = 2'd0;
        for (int k = 24; k < 30; k++) begin
            cyc(1, 0, 8'h01, 3'd0, (k % 3 == 0), 1, "last0");
        end

        mode_a = 1'b0; iv_a = 1'b1; i_a = 2'd2;
        cyc(1, 0, 8'h04, 3'd2, 0, 1, "scan2direct");

        en_a = 1'b0; iv_a = 1'b0;
        cyc(1, 0, 8'h00, 3'd0, 0, 0, "disable");

        en_a = 1'b1; mode_a = 1'b1; last_a = 2'd3;
        for (int k = 0; k < 4; k++) begin
            id = k / 3;
            cyc(1, 0, 8'd1 << id, 3'(id), (k == 3), 1, "reenable");
        end

        mode_a = 1'b0; iv_a = 1'b0;
        cyc(1, 0, 8'h00, 3'd0, 0, 1, "direct_noval");
        iv_a = 1'b1; i_a = 2'd1;
        cyc(1, 0, 8'h02, 3'd1, 0, 1, "direct_after");
        en_a = 1'b0; iv_a = 1'b0;

        rst_nb = 1'b1; en_b = 1'b1; mode_b = 1'b1; last_b = 3'd7; iv_b = 1'b1; i_b = 3'd6;
        for (int k = 0; k < 12; k++) begin
            id = (k / 2) % 8;
            cyc(1, 1, ~(8'd1 << id), 3'(id), (k > 0) && (k % 2 == 0), 1, "scan_b");
        end

        rst_nb = 1'b0;
        cyc(1, 1, 8'hFF, 3'd0, 0, 0, "rst_mid_b");
        cyc(1, 1, 8'hFF, 3'd0, 0, 0, "rst_hold_b");

        rst_nb = 1'b1;
        cyc(1, 1, 8'hFE, 3'd0, 0, 1, "reentry_b0");
        cyc(1, 1, 8'hFE, 3'd0, 0, 1, "reentry_b1");
        cyc(1, 1, 8'hFD, 3'd1, 1, 1, "reentry_b2");

        @(posedge clk);
        #2;
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expectations, want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
